// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC owner and instruction-memory sequencer.
// One outstanding request; redirect, stall, halt and drop handling.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        ifv_q, ifv_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifins_q, ifins_d;
  logic        req;
  logic        load;

  assign req = (state_q == S_FETCH) & ~stall & ~halt
             & ~redirect_valid & ~rst;

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign if_valid  = ifv_q;
  assign if_pc     = ifpc_q;
  assign if_instr  = ifins_q;
  assign halted    = (state_q == S_HALT);

  // Next-state: fetch sequencing, redirect/drop, halt drain, IF register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    ifv_d   = ifv_q;
    ifpc_d  = ifpc_q;
    ifins_d = ifins_q;
    load    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (req && imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (halt) begin
          // A response landing with halt is simply the drained one.
          state_d = imem_rvalid ? S_HALT : S_DRAIN;
          drop_d  = 1'b0;
        end else if (imem_rvalid) begin
          state_d = S_FETCH;
          drop_d  = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_target;
          end else if (!drop_q) begin
            load = 1'b1;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_target;
          drop_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase

    if (ifv_q && !stall) begin
      ifv_d = 1'b0;
    end
    if (halt || redirect_valid || state_q == S_HALT) begin
      ifv_d = 1'b0;
    end
    if (load) begin
      ifv_d   = 1'b1;
      ifpc_d  = pc_q;
      ifins_d = imem_rdata;
      pc_d    = pc_q + 32'd1;
    end
  end

  // State, PC and IF output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      ifv_q   <= 1'b0;
      ifpc_q  <= 32'h0;
      ifins_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      ifv_q   <= ifv_d;
      ifpc_q  <= ifpc_d;
      ifins_q <= ifins_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run
// against a transaction-level fetch model and memory responder.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0010;
  localparam logic [31:0] XORK   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .pc(pc), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory responder: grant after gnt_delay cycles of request,
  // data rv_lat cycles after grant, data = addr ^ XORK.
  int          gnt_delay = 0;
  int          rv_lat = 1;
  int          age = 0;
  logic        resp_v = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;

  assign imem_gnt    = imem_req && (age >= gnt_delay);
  assign imem_rvalid = resp_v && (resp_cnt == 0);
  assign imem_rdata  = imem_rvalid ? (resp_addr ^ XORK) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age    <= 0;
      resp_v <= 1'b0;
      resp_cnt <= 0;
    end else begin
      if (imem_rvalid) resp_v <= 1'b0;
      else if (resp_v && resp_cnt > 0) resp_cnt <= resp_cnt - 1;
      if (imem_req && imem_gnt) begin
        resp_v    <= 1'b1;
        resp_cnt  <= rv_lat - 1;
        resp_addr <= imem_addr;
        age       <= 0;
      end else if (imem_req) begin
        age <= age + 1;
      end else begin
        age <= 0;
      end
    end
  end

  // Reference model in terms of transactions: busy = a request is
  // outstanding, discard = its data is stale, stopping = halting.
  logic [31:0] m_pc = RST_PC;
  logic        m_busy = 1'b0;
  logic        m_discard = 1'b0;
  logic        m_stopping = 1'b0;
  logic        m_halted = 1'b0;
  logic        m_ifv = 1'b0;
  logic [31:0] m_ifpc = 32'h0;
  logic [31:0] m_ifins = 32'h0;
  logic        m_req;

  assign m_req = !rst && !m_busy && !m_halted && !stall
               && !halt && !redirect_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RST_PC; m_busy <= 1'b0; m_discard <= 1'b0;
      m_stopping <= 1'b0; m_halted <= 1'b0;
      m_ifv <= 1'b0; m_ifpc <= 32'h0; m_ifins <= 32'h0;
    end else if (m_halted) begin
      m_ifv <= 1'b0;
    end else if (m_stopping) begin
      if (imem_rvalid) begin
        m_halted <= 1'b1; m_stopping <= 1'b0; m_busy <= 1'b0;
      end
    end else if (halt) begin
      m_ifv <= 1'b0;
      if (m_busy && !imem_rvalid) m_stopping <= 1'b1;
      else begin m_halted <= 1'b1; m_busy <= 1'b0; end
    end else if (redirect_valid) begin
      m_ifv <= 1'b0;
      m_pc  <= redirect_target;
      if (m_busy) begin
        m_busy    <= !imem_rvalid;
        m_discard <= !imem_rvalid;
      end
    end else if (m_busy) begin
      if (imem_rvalid && !m_discard) begin
        m_busy <= 1'b0;
        m_ifv <= 1'b1; m_ifpc <= m_pc; m_ifins <= imem_rdata;
        m_pc <= m_pc + 32'd1;
      end else begin
        if (imem_rvalid) begin m_busy <= 1'b0; m_discard <= 1'b0; end
        if (!stall) m_ifv <= 1'b0;
      end
    end else begin
      if (!stall && imem_gnt) begin
        m_busy <= 1'b1; m_discard <= 1'b0;
      end
      if (!stall) m_ifv <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ifv(input string nm);
    int k;
    k = 0;
    while (if_valid !== 1'b1 && k < 20) begin tick(); k++; end
    if (k == 20) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout if_valid never rose", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (pc !== RST_PC) begin n_fail++;
      $display("FAIL rst_pc got %h want %h", pc, RST_PC); end
    n_tests++;
    if (if_valid !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got v%b h%b r%b want 000",
               if_valid, halted, imem_req);
    end
    n_tests++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_fail++;
      $display("FAIL rst_if got %h/%h want 0/0", if_pc, if_instr); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic        ev;
    gnt_delay = 0; rv_lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a  = RST_PC + 32'(i / 2);
      ev = (i % 2 == 0);
      n_tests++;
      if (imem_req !== ev) begin n_fail++;
        $display("FAIL seq_req[%0d] got %b want %b", i, imem_req, ev); end
      if (ev) begin
        n_tests++;
        if (imem_addr !== a) begin n_fail++;
          $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, a); end
      end
      n_tests++;
      if (if_valid !== (ev && i > 0)) begin n_fail++;
        $display("FAIL seq_ifv[%0d] got %b", i, if_valid); end
      if (ev && i > 0) begin
        n_tests++;
        if (if_pc !== a - 1 || if_instr !== ((a - 1) ^ XORK)) begin
          n_fail++;
          $display("FAIL seq_if[%0d] got %h/%h want %h/%h", i,
                   if_pc, if_instr, a - 1, (a - 1) ^ XORK);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_wait();
    int k;
    gnt_delay = 0; rv_lat = 3;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL rw_req got %b want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h40) begin n_fail++;
      $display("FAIL rw_pc got %h want 40", pc); end
    for (k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (if_valid !== 1'b0) begin n_fail++;
        $display("FAIL rw_drop got if_valid %b want 0", if_valid); end
      if (imem_req === 1'b1) break;
    end
    n_tests++;
    if (k == 10 || imem_addr !== 32'h40) begin n_fail++;
      $display("FAIL rw_next got %h want 40", imem_addr); end
    tick();
  endtask

  task automatic test_redirect_rvalid();
    int k;
    gnt_delay = 0; rv_lat = 1;
    do_reset();
    k = 0;
    while (imem_rvalid !== 1'b1 && k < 10) begin tick(); k++; end
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_valid !== 1'b0 || pc !== 32'h40) begin n_fail++;
      $display("FAIL rr_drop got v%b pc %h want 0/40", if_valid, pc); end
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++;
      $display("FAIL rr_next got %b/%h want 1/40", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_stall();
    gnt_delay = 0; rv_lat = 1;
    do_reset();
    wait_ifv("stall");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== RST_PC
          || if_instr !== (RST_PC ^ XORK) || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v%b %h %h r%b", i,
                 if_valid, if_pc, if_instr, imem_req);
      end
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC + 1) begin n_fail++;
      $display("FAIL stall_rel got %b/%h want 1/%h",
               imem_req, imem_addr, RST_PC + 1);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (if_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_consume got %b want 0", if_valid); end
    tick();
    @(negedge clk);
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== RST_PC + 1) begin n_fail++;
      $display("FAIL stall_next got %b/%h want 1/%h",
               if_valid, if_pc, RST_PC + 1);
    end
    tick();
  endtask

  task automatic test_wrap();
    gnt_delay = 0; rv_lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    wait_ifv("wrap");
    @(negedge clk);
    n_tests++;
    if (pc !== 32'h0 || if_pc !== 32'hFFFF_FFFF) begin n_fail++;
      $display("FAIL wrap got pc %h if_pc %h want 0/ffffffff", pc, if_pc);
    end
    n_tests++;
    if (if_instr !== 32'h5A5A_5A5A) begin n_fail++;
      $display("FAIL wrap_instr got %h want 5a5a5a5a", if_instr); end
    tick();
  endtask

  task automatic test_halt();
    int k;
    gnt_delay = 0; rv_lat = 3;
    do_reset();
    wait_ifv("halt");
    tick();
    halt = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL halt_req got %b want 0", imem_req); end
    tick();
    halt = 1'b0;
    for (k = 0; k < 10; k++) begin
      if (imem_rvalid === 1'b1) break;
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b0 || imem_req !== 1'b0) begin n_fail++;
        $display("FAIL halt_drain got h%b r%b want 0/0", halted, imem_req);
      end
      tick();
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (halted !== 1'b1 || pc !== RST_PC + 1 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter got h%b pc %h v%b", halted, pc, if_valid);
    end
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h40; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (pc !== RST_PC + 1 || halted !== 1'b1 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_ignore[%0d] got pc %h h%b r%b", i,
                 pc, halted, imem_req);
      end
      tick();
    end
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++;
      $display("FAIL halt_stay got h%b r%b", halted, imem_req); end
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (pc !== RST_PC || halted !== 1'b0) begin n_fail++;
      $display("FAIL halt_rst got pc %h h%b", pc, halted); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_gnt_delay();
    int k;
    gnt_delay = 3; rv_lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++;
        $display("FAIL gd_stable[%0d] got %b/%h", i, imem_req, imem_addr);
      end
      tick();
    end
    wait_ifv("gd");
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h80;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL gd_redir_req got %b want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++;
        $display("FAIL gd_target got %b/%h want 1/80", imem_req, imem_addr);
      end
      if (imem_gnt === 1'b1) break;
      tick();
    end
    tick();
    wait_ifv("gd2");
    n_tests++;
    if (if_pc !== 32'h80 || if_instr !== (32'h80 ^ XORK)) begin n_fail++;
      $display("FAIL gd_if got %h/%h want 80", if_pc, if_instr); end
    tick();
  endtask

  task automatic test_random();
    gnt_delay = 0; rv_lat = 1;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      stall = ($urandom % 4 == 0);
      redirect_valid = ($urandom % 12 == 0);
      redirect_target = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
      halt = ($urandom % 80 == 0);
      gnt_delay = int'($urandom % 3);
      rv_lat = 1 + int'($urandom % 3);
      rst = (m_halted && $urandom % 4 == 0) || ($urandom % 300 == 0);
      @(negedge clk);
      n_tests++;
      if (imem_req !== m_req || imem_addr !== m_pc || pc !== m_pc) begin
        n_fail++;
        $display("FAIL rnd_pc[%0d] got r%b %h %h want r%b %h", c,
                 imem_req, imem_addr, pc, m_req, m_pc);
      end
      n_tests++;
      if (if_valid !== m_ifv || halted !== m_halted) begin n_fail++;
        $display("FAIL rnd_flags[%0d] got v%b h%b want v%b h%b", c,
                 if_valid, halted, m_ifv, m_halted);
      end
      n_tests++;
      if (if_pc !== m_ifpc || if_instr !== m_ifins) begin n_fail++;
        $display("FAIL rnd_if[%0d] got %h/%h want %h/%h", c,
                 if_pc, if_instr, m_ifpc, m_ifins);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_redirect_rvalid();
    test_stall();
    test_wrap();
    test_halt();
    test_gnt_delay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch from instruction memory. It holds the PC register, issues one outstanding fetch request at a time, increments the PC by one word on every delivered instruction, and applies branch/jump redirects, hazard stalls and halt. It sits between the hazard/branch logic and the instruction memory, and feeds the IF/ID boundary.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall. Blocks new requests and holds the IF output.
- redirect_valid  in  1  taken branch/jump from a later stage.
- redirect_target  in  32  new PC when redirect_valid=1.
- halt  in  1  stop fetching. Only rst leaves the halted state.
- imem_req  out  1  fetch request, combinational.
- imem_addr  out  32  fetch word address; always equals pc.
- imem_gnt  in  1  request accepted in this cycle; meaningful only while imem_req=1.
- imem_rvalid  in  1  read data valid; occurs at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- pc  out  32  current PC register.
- if_valid  out  1  instruction valid to decode.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- halted  out  1  high in HALT.

## Operation

- States:
  - FETCH: ready to issue.
  - WAIT: one request outstanding.
  - DRAIN: halt pending with a request outstanding.
  - HALT: stopped.
- drop flag: set when the outstanding response must be discarded.
- Per-cycle priority: rst > halt > redirect_valid > stall.
- imem_req = (state==FETCH) & !stall & !halt & !redirect_valid & !rst.
- FETCH:
  - imem_req & imem_gnt -> WAIT, drop=0.
  - redirect_valid -> pc<=redirect_target, stay in FETCH.
  - halt -> HALT.
- WAIT:
  - imem_rvalid & !drop & !redirect_valid -> if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1, go to FETCH.
  - imem_rvalid & drop -> discard the response, drop<=0, go to FETCH. pc is unchanged.
  - redirect_valid without rvalid -> pc<=redirect_target, drop<=1, stay in WAIT.
  - redirect_valid with rvalid -> discard the response, pc<=redirect_target, drop<=0, go to FETCH.
  - halt -> DRAIN.
- DRAIN: on imem_rvalid, discard the response and go to HALT. redirect_valid is ignored.
- HALT:
  - imem_req=0, halted=1.
  - redirect_valid and stall are ignored.
  - The IF output holds its last value and if_valid is cleared.
- IF output register:
  - An instruction is consumed at any rising edge where if_valid=1 and stall=0.
  - After consumption, if_valid<=0 unless a new instruction is loaded at the same edge.
  - While stall=1, if_valid, if_pc and if_instr hold.
  - redirect_valid or halt clears if_valid at the next edge (flush), regardless of stall.
- A response never arrives while an unconsumed instruction is held. Requests are issued only with stall=0, and that edge consumes any held instruction. No additional buffering is required.
- Arithmetic: pc+1 is a 32-bit word increment with wrap-around, so 32'hFFFF_FFFF -> 32'h0000_0000.
- imem_addr is stable while imem_req=1 and imem_gnt=0. It changes only on redirect, and on that cycle imem_req drops.

## Timing

- Reset values:
  - pc=RESET_PC, state=FETCH, drop=0.
  - if_valid=0, if_pc=0, if_instr=0, halted=0.
  - imem_req=0 while rst=1.
- rst asserted mid-transaction abandons the outstanding request. Any late imem_rvalid after rst deasserts is undefined; the memory is reset together with this block.
- Latency: imem_rvalid in cycle t gives if_valid=1 and the incremented pc in cycle t+1.
- Best-case throughput is one instruction per 2 cycles: gnt in the same cycle as req, rvalid one cycle later.
- redirect_valid in cycle t gives pc=redirect_target in cycle t+1. The first request to the target is at t+1 if no response is outstanding.
- halt in cycle t gives HALT at t+1 from FETCH. From WAIT, HALT follows the edge after the pending imem_rvalid.

## Test plan

- Reset with RESET_PC=32'h10, memory with gnt same cycle and rvalid +1 returning data=addr^32'hA5A5_A5A5.
  - Requests go to 0x10, 0x11, 0x12.
  - if_valid pulses every 2 cycles with matching if_pc and if_instr.
- Redirect to 32'h40 while in WAIT (no rvalid yet):
  - The returning response is dropped and if_valid stays 0.
  - The next request address is 0x40.
  - Repeat with redirect and rvalid in the same cycle: the response is dropped and the next request is 0x40.
- Stall held 5 cycles with if_valid=1:
  - if_pc and if_instr are frozen and imem_req=0.
  - After release, exactly one consumption occurs, followed by a request to pc.
- pc=32'hFFFF_FFFF fetch completes -> pc=32'h0000_0000 and if_pc=32'hFFFF_FFFF.
- halt during WAIT:
  - The state passes through DRAIN and the response is discarded.
  - halted=1 after rvalid, and later redirect_valid has no effect.
  - Asserting rst restores pc=RESET_PC and halted=0.
- gnt delayed 3 cycles:
  - imem_addr stays stable throughout.
  - A redirect during the delay deasserts imem_req that cycle, and the next request goes to the target.
